// File: rtl/fetch_stage.sv
// Pipeline fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional saturating stall/flush performance counters are built when PERF_CNT_EN is defined.
module fetch_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF_i,
    input  logic             StallD_i,
    input  logic             FlushD_i,
    input  logic [1:0]       PCSrcE_i,
    input  logic [WIDTH-1:0] PCTargetE_i,
    input  logic [WIDTH-1:0] ALUResultE_i,
    input  logic [WIDTH-1:0] InstrF_i,
    output logic [WIDTH-1:0] PCF_o,
    output logic [WIDTH-1:0] InstrD_o,
    output logic [WIDTH-1:0] PCD_o,
    output logic [WIDTH-1:0] PCPlus4D_o,
    output logic             ValidD_o,
    output logic [31:0]      StallCnt_o,
    output logic [31:0]      FlushCnt_o
);

    typedef enum logic [1:0] {
        SRC_PLUS4  = 2'b00,
        SRC_TARGET = 2'b01,
        SRC_JALR   = 2'b10,
        SRC_RSVD   = 2'b11
    } pc_src_e;

    logic [WIDTH-1:0] pc_plus4_f;
    logic [WIDTH-1:0] pc_next_f;

    // Wraps naturally at 2^WIDTH.
    assign pc_plus4_f = PCF_o + WIDTH'(4);

    // NOTE: pc_next_f gets a default before the case so no latch is inferred
    // for any PCSrcE_i value.
    always_comb begin
        pc_next_f = pc_plus4_f;
        case (pc_src_e'(PCSrcE_i))
            SRC_TARGET: pc_next_f = PCTargetE_i;
            SRC_JALR:   pc_next_f = {ALUResultE_i[WIDTH-1:1], 1'b0};
            default:    pc_next_f = pc_plus4_f;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF_o <= RESET_PC;
        end else if (!StallF_i) begin
            PCF_o <= pc_next_f;
        end
    end

    // Flush wins over stall so a squashed instruction never lingers in Decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD_o   <= NOP_INSTR;
            PCD_o      <= '0;
            PCPlus4D_o <= '0;
            ValidD_o   <= 1'b0;
        end else if (FlushD_i) begin
            InstrD_o   <= NOP_INSTR;
            PCD_o      <= '0;
            PCPlus4D_o <= '0;
            ValidD_o   <= 1'b0;
        end else if (!StallD_i) begin
            InstrD_o   <= InstrF_i;
            PCD_o      <= PCF_o;
            PCPlus4D_o <= pc_plus4_f;
            ValidD_o   <= 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF_i && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (FlushD_i && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign StallCnt_o = stall_cnt;
    assign FlushCnt_o = flush_cnt;
`else
    assign StallCnt_o = 32'd0;
    assign FlushCnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver pushes expected post-edge state,
// monitor pops and compares one cycle-step after each rising edge.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc4;
        logic        v;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_f = 1'b0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] pc_target = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] instr_f;
    logic [31:0] pcf;
    logic [31:0] instr_d;
    logic [31:0] pcd;
    logic [31:0] pc4d;
    logic        valid_d;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    exp_t        exp_q[$];
    int          tests  = 0;
    int          failed = 0;
    int unsigned exp_sc = 0;
    int unsigned exp_fc = 0;

    always #5 clk = ~clk;

    // Instruction memory: combinational, PC-derived pattern.
    assign instr_f = pcf + 32'h1000_0000;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .StallF_i     (stall_f),
        .StallD_i     (stall_d),
        .FlushD_i     (flush_d),
        .PCSrcE_i     (pc_src),
        .PCTargetE_i  (pc_target),
        .ALUResultE_i (alu_result),
        .InstrF_i     (instr_f),
        .PCF_o        (pcf),
        .InstrD_o     (instr_d),
        .PCD_o        (pcd),
        .PCPlus4D_o   (pc4d),
        .ValidD_o     (valid_d),
        .StallCnt_o   (stall_cnt),
        .FlushCnt_o   (flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int unsigned c);
`ifdef PERF_CNT_EN
        return c;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_pcf"},   pcf,          32'h0000_0000);
        check({tag, "_instr"}, instr_d,      32'h0000_0013);
        check({tag, "_pcd"},   pcd,          32'h0000_0000);
        check({tag, "_pc4"},   pc4d,         32'h0000_0000);
        check({tag, "_valid"}, {31'd0, valid_d}, 32'd0);
        check({tag, "_scnt"},  stall_cnt,    32'd0);
        check({tag, "_fcnt"},  flush_cnt,    32'd0);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the state
    // expected after the next rising edge.
    task automatic vec(input logic sf, input logic sd, input logic fd,
                       input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_pcd, input logic [31:0] e_pc4, input logic e_v);
        exp_t e;
        @(negedge clk);
        rst        = 1'b0;
        stall_f    = sf;
        stall_d    = sd;
        flush_d    = fd;
        pc_src     = src;
        pc_target  = tgt;
        alu_result = alu;
        if (sf) exp_sc++;
        if (fd) exp_fc++;
        e.pc    = e_pc;
        e.instr = e_instr;
        e.pcd   = e_pcd;
        e.pc4   = e_pc4;
        e.v     = e_v;
        e.sc    = cnt_exp(exp_sc);
        e.fc    = cnt_exp(exp_fc);
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new pipeline state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pcf",   pcf,     e.pc);
                check("instr", instr_d, e.instr);
                check("pcd",   pcd,     e.pcd);
                check("pc4",   pc4d,    e.pc4);
                check("valid", {31'd0, valid_d}, {31'd0, e.v});
                check("scnt",  stall_cnt, e.sc);
                check("fcnt",  flush_cnt, e.fc);
            end
        end
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_reset_state("rst");

        //   sf  sd  fd  src    target        alu           pcf           instrD        pcD           pc4D          v
        vec(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0004, 32'h1000_0000, 32'h0000_0000, 32'h0000_0004, 1);
        vec(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0008, 32'h1000_0004, 32'h0000_0004, 32'h0000_0008, 1);
        // Full stall for three cycles at PC 8.
        vec(1, 1, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0008, 32'h1000_0004, 32'h0000_0004, 32'h0000_0008, 1);
        vec(1, 1, 0, 2'b01, 32'h300,      32'h0,        32'h0000_0008, 32'h1000_0004, 32'h0000_0004, 32'h0000_0008, 1);
        vec(1, 1, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0008, 32'h1000_0004, 32'h0000_0004, 32'h0000_0008, 1);
        vec(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_000C, 32'h1000_0008, 32'h0000_0008, 32'h0000_000C, 1);
        // Taken branch with flush.
        vec(0, 0, 1, 2'b01, 32'h100,      32'h0,        32'h0000_0100, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0);
        vec(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0104, 32'h1000_0100, 32'h0000_0100, 32'h0000_0104, 1);
        // JALR target has bit 0 cleared.
        vec(0, 0, 0, 2'b10, 32'h0,        32'h205,      32'h0000_0204, 32'h1000_0104, 32'h0000_0104, 32'h0000_0108, 1);
        vec(0, 0, 0, 2'b11, 32'h400,      32'h401,      32'h0000_0208, 32'h1000_0204, 32'h0000_0204, 32'h0000_0208, 1);
        // Independent stalls: PC held while Decode loads, then the reverse.
        vec(1, 0, 0, 2'b01, 32'h500,      32'h0,        32'h0000_0208, 32'h1000_0208, 32'h0000_0208, 32'h0000_020C, 1);
        vec(0, 1, 0, 2'b00, 32'h0,        32'h0,        32'h0000_020C, 32'h1000_0208, 32'h0000_0208, 32'h0000_020C, 1);
        // Flush beats stall.
        vec(0, 1, 1, 2'b00, 32'h0,        32'h0,        32'h0000_0210, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0);
        // PC wrap-around at the top of the address space.
        vec(0, 0, 0, 2'b01, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 32'h1000_0210, 32'h0000_0210, 32'h0000_0214, 1);
        vec(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0000, 32'h0FFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1);
        vec(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0004, 32'h1000_0000, 32'h0000_0000, 32'h0000_0004, 1);
        vec(1, 1, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0004, 32'h1000_0000, 32'h0000_0000, 32'h0000_0004, 1);

        // Reset asserted between edges during a stall must act immediately.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        exp_sc = 0;
        exp_fc = 0;

        // First fetch after release comes from the reset PC.
        vec(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0004, 32'h1000_0000, 32'h0000_0000, 32'h0000_0004, 1);

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: address/instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013: bubble instruction (addi x0,x0,0).
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port StallF_i  in  1  hold the PC register.
REQ-007 SHALL have port StallD_i  in  1  hold the IF/ID register.
REQ-008 SHALL have port FlushD_i  in  1  replace IF/ID contents with a bubble.
REQ-009 SHALL have port PCSrcE_i  in  2  next-PC select: 00 PC+4, 01 PCTargetE_i, 10 ALUResultE_i with bit 0 cleared, 11 PC+4.
REQ-010 SHALL have port PCTargetE_i  in  WIDTH  branch/JAL target from Execute.
REQ-011 SHALL have port ALUResultE_i  in  WIDTH  JALR target from Execute.
REQ-012 SHALL have port InstrF_i  in  WIDTH  instruction memory read data (combinational from PCF_o).
REQ-013 SHALL have port PCF_o  out  WIDTH  current fetch address.
REQ-014 SHALL have port InstrD_o  out  WIDTH  Decode-stage instruction.
REQ-015 SHALL have port PCD_o  out  WIDTH  Decode-stage PC.
REQ-016 SHALL have port PCPlus4D_o  out  WIDTH  Decode-stage PC+4.
REQ-017 SHALL have port ValidD_o  out  1  Decode slot holds a real fetched instruction.
REQ-018 SHALL have ports StallCnt_o and FlushCnt_o  out  32 each  performance counters (see Configuration).

Function
REQ-019 SHALL compute PCPlus4F = PCF_o + 4 modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0.
REQ-020 SHALL, each rising edge with StallF_i low, load PCF_o with the PCSrcE_i-selected next PC.
REQ-021 SHALL hold PCF_o when StallF_i is high, regardless of PCSrcE_i.
REQ-022 SHALL, when FlushD_i is high, load InstrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=0, ValidD_o=0 at the next edge.
REQ-023 SHALL give FlushD_i priority over StallD_i when both are high.
REQ-024 SHALL hold InstrD_o, PCD_o, PCPlus4D_o, ValidD_o when StallD_i is high and FlushD_i is low.
REQ-025 SHALL otherwise load InstrF_i, PCF_o, PCPlus4F into the IF/ID register and set ValidD_o=1.
REQ-026 SHALL have one-cycle latency: an instruction at PCF_o in cycle n appears on InstrD_o in cycle n+1 absent stall/flush.
REQ-027 SHALL not assume relation between StallF_i and StallD_i; each register obeys only its own control.
REQ-028 SHALL produce no combinational path from any input to InstrD_o, PCD_o, PCPlus4D_o, ValidD_o.

Reset
REQ-029 SHALL, while rst is high, force PCF_o=RESET_PC, InstrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=0, ValidD_o=0, counters=0, independent of clk.
REQ-030 SHALL take the first fetch after rst falls from RESET_PC; reset mid-stall discards held state.

Configuration
REQ-031 SHALL, with PERF_CNT_EN defined, increment StallCnt_o each edge StallF_i is high and FlushCnt_o each edge FlushD_i is high; both saturate at 32'hFFFF_FFFF.
REQ-032 SHALL, without PERF_CNT_EN, tie StallCnt_o and FlushCnt_o to 0 and implement no counter flops.

Verification
REQ-033 SHALL cover: reset release, InstrF_i=PC-based pattern -> PCF_o 0,4,8,C; InstrD_o lags one cycle; ValidD_o=1 from the second edge.
REQ-034 SHALL cover: StallF_i=StallD_i=1 for 3 cycles at PCF_o=8 -> PCF_o stays 8, InstrD_o/PCD_o unchanged; StallCnt_o += 3 with PERF_CNT_EN.
REQ-035 SHALL cover: PCSrcE_i=01, PCTargetE_i=0x100, FlushD_i=1 -> next PCF_o=0x100, InstrD_o=0x00000013, ValidD_o=0.
REQ-036 SHALL cover: PCSrcE_i=10, ALUResultE_i=0x205 -> PCF_o=0x204.
REQ-037 SHALL cover: FlushD_i=StallD_i=1 same cycle -> bubble loaded; and rst asserted mid-stall between edges -> outputs reset immediately.
REQ-038 SHALL cover: PCF_o=0xFFFF_FFFC, PCSrcE_i=00 -> PCF_o=0, PCPlus4D_o=0 on the following cycle.
